// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and instruction fetch stage ahead of decode
//
// Optional feature macro: IFU_FAULT_EN
//   defined   : a misaligned redirect target traps into a sticky FAULT state
//   undefined : redirect target bits [1:0] are cleared, fetch_fault is 0
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   imem_req/imem_addr (out)       fetch request and address (= pc)
//   imem_ack/imem_rdata (in)       fetch completion and instruction word
//   instr/opcode/funct (out)       registered instruction and its fields
//   instr_valid (out)              instruction presented to decode
//   stall (in)                     downstream hold, blocks retire
//   branch/branch_taken/branch_target (in)   conditional redirect
//   jump/jump_target (in)          unconditional redirect
//   pc/pc_plus4 (out)              current instruction address and link value
//   fetch_fault (out)              misaligned redirect trap
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

`ifdef IFU_FAULT_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;

  logic        w_retire;
  logic        w_redirect;
  logic        w_fault_trap;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_retire   = (r_state == S_HOLD) && !stall;

  // Jump outranks a taken branch; branch_taken means nothing without branch.
  assign w_redirect = jump || (branch && branch_taken);
  assign w_target   = jump ? jump_target : branch_target;
  assign w_next_pc  = w_redirect ? (w_target & ~32'd3) : w_pc_plus4;

`ifdef IFU_FAULT_EN
  assign w_fault_trap = w_redirect && (w_target[1:0] != 2'b00);
`else
  assign w_fault_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    case (r_state)
      S_IDLE:  w_next_state = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next_state = S_HOLD;
      end
`ifdef IFU_FAULT_EN
      S_HOLD:  if (!stall) w_next_state = w_fault_trap ? S_FAULT : S_FETCH;
      S_FAULT: w_next_state = S_FAULT;
`else
      S_HOLD:  if (!stall) w_next_state = S_FETCH;
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
    end else begin
      // Ack only counts while the request is actually up.
      if (r_state == S_FETCH && imem_ack) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_retire) begin
        r_instr_valid <= 1'b0;
        // A trapped redirect leaves pc pointing at the faulting instruction.
        if (!w_fault_trap) r_pc <= w_next_pc;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign funct       = r_instr[5:0];
  assign instr_valid = r_instr_valid;
`ifdef IFU_FAULT_EN
  assign fetch_fault = (r_state == S_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  // Second instance parked at the top of the address space, always acked.
  logic        wr_one = 1'b1;
  logic        wr_zero = 1'b0;
  logic [31:0] wr_zero32 = 32'd0;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_instr;
  logic [5:0]  wr_opcode;
  logic [5:0]  wr_funct;
  logic        wr_valid;
  logic [31:0] wr_pc;
  logic [31:0] wr_pc_plus4;
  logic        wr_fault;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
    .stall(stall), .branch(branch), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_fault(fetch_fault)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(wr_req), .imem_addr(wr_addr),
    .imem_ack(wr_one), .imem_rdata(wr_zero32),
    .instr(wr_instr), .opcode(wr_opcode), .funct(wr_funct), .instr_valid(wr_valid),
    .stall(wr_zero), .branch(wr_zero), .branch_taken(wr_zero),
    .branch_target(wr_zero32), .jump(wr_zero), .jump_target(wr_zero32),
    .pc(wr_pc), .pc_plus4(wr_pc_plus4), .fetch_fault(wr_fault)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  bit          mon_en = 1'b0;

  // Memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: scoreboard had no expected entry", name);
  endtask

  // Monitor: compares fetch addresses and each newly presented instruction
  // against the queue of PCs the reference model predicted.
  initial begin
    logic        prev_valid;
    logic [31:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (imem_req) begin
          if (exp_q.size() == 0) report_fail("imem_addr");
          else check("imem_addr", imem_addr, exp_q[0]);
        end
        if (instr_valid && !prev_valid) begin
          if (exp_q.size() == 0) report_fail("instr");
          else begin
            e = exp_q.pop_front();
            check("pc", pc, e);
            check("pc_plus4", pc_plus4, e + 32'd4);
            check("instr", instr, mem_word(e));
            check("opcode", {26'd0, opcode}, {26'd0, mem_word(e) >> 26});
            check("funct", {26'd0, funct}, {26'd0, mem_word(e) & 32'h3F});
          end
        end
      end
      prev_valid = instr_valid;
    end
  end

  // Called at posedge+1; drives one cycle of inputs and, when this cycle
  // retires, records the PC the fetch unit must go to next.
  task automatic drive_cycle(input bit ack, input bit stl, input bit jmp, input bit br,
                             input bit tk, input logic [31:0] jt, input logic [31:0] bt);
    logic [31:0] nxt;
    bit          trap;
    imem_ack      = ack;
    imem_rdata    = imem_req ? mem_word(imem_addr) : $urandom;
    stall         = stl;
    jump          = jmp;
    branch        = br;
    branch_taken  = tk;
    jump_target   = jt;
    branch_target = bt;
    if (instr_valid && !stl) begin
      trap = 1'b0;
      if (jmp) nxt = jt;
      else if (br && tk) nxt = bt;
      else nxt = m_pc + 32'd4;
`ifdef IFU_FAULT_EN
      trap = (nxt[1:0] != 2'b00);
`endif
      nxt[1:0] = 2'b00;
      if (!trap) begin
        m_pc = nxt;
        exp_q.push_back(nxt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    mon_en = 1'b0;
    rst_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    stall = 1'b0;
    jump = 1'b0;
    branch = 1'b0;
    @(posedge clk);
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_opcode", {26'd0, opcode}, 32'd0);
    check("rst_funct", {26'd0, funct}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("wrap_rst_pc", wr_pc, 32'hFFFF_FFFC);
    check("wrap_rst_pc_plus4", wr_pc_plus4, 32'h0);
    exp_q.delete();
    m_pc = 32'h0;
    exp_q.push_back(32'h0);
    rst_n = 1'b1;
    // ack still high through IDLE: it must not be taken as a fetch.
    @(posedge clk);
    #1;
    check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("idle_to_fetch_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    logic [31:0] jt;
    logic [31:0] bt;

    // 1: ack always high, valid alternates, addresses 0,4,8...
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      check("valid_pulse", {31'd0, instr_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 1) begin
        check("wrap_pc", wr_pc, 32'h0);
        check("wrap_pc_plus4", wr_pc_plus4, 32'h4);
      end
    end

    // 2: delayed ack at pc=0x10
    reset_dut();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("delay_req", {31'd0, imem_req}, 32'd1);
      check("delay_addr", imem_addr, 32'h10);
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    check("delay_req", {31'd0, imem_req}, 32'd1);
    check("delay_valid_before", {31'd0, instr_valid}, 32'd0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("delay_valid_after", {31'd0, instr_valid}, 32'd1);
    check("delay_instr", instr, mem_word(32'h10));

    // 3: stalled in HOLD, redirect inputs must be ignored
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h800, 32'h900);
      check("stall_pc", pc, 32'h10);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h800, 32'h900);
    check("unstall_pc", pc, 32'h14);
    check("unstall_req", {31'd0, imem_req}, 32'd1);

    // 4: jump beats taken branch; untaken branch falls through
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200);
    check("jump_prio_pc", pc, 32'h100);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h200);
    check("branch_not_taken_pc", pc, 32'h104);

    // 6: misaligned jump target 0x102
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h102, 32'd0);
`ifdef IFU_FAULT_EN
    for (int i = 0; i < 3; i++) begin
      check("fault_flag", {31'd0, fetch_fault}, 32'd1);
      check("fault_req", {31'd0, imem_req}, 32'd0);
      check("fault_valid", {31'd0, instr_valid}, 32'd0);
      check("fault_pc", pc, 32'h104);
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
`else
    check("misalign_pc", pc, 32'h100);
    check("misalign_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    reset_dut();
    // Second reset lands while FETCH is active.
    reset_dut();

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      jt = $urandom;
      bt = $urandom;
`ifdef IFU_FAULT_EN
      jt[1:0] = 2'b00;
      bt[1:0] = 2'b00;
`endif
      drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1, jt, bt);
      check("rand_fault", {31'd0, fetch_fault}, 32'd0);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
